// File: rtl/seq_mul_add_nat_pkg.sv
// Shared constants for the sequential digit-serial multiply-accumulate.
package seq_mul_add_nat_pkg;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_mul_add_nat_digit_mac.sv
// add: N-bit natural adder, result truncated to N bits.
// Latency: combinational.
// Backpressure: none.
module add #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s
);
    assign s = a + b;
endmodule

// mul_add_nat: m = a*b + d on N-bit naturals, 2N-bit result (never overflows).
// Latency: combinational.
// Backpressure: none.
module mul_add_nat #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   d,
    output logic [2*N-1:0] m
);
    assign m = {{N{1'b0}}, a} * {{N{1'b0}}, b} + {{N{1'b0}}, d};
endmodule

// digit_mac: t = a*b + d + e on 4-bit digits; max 15*15+15+15 = 255 fits in 8 bits.
// Latency: combinational.
// Backpressure: none.
module digit_mac
    import seq_mul_add_nat_pkg::*;
(
    input  logic [DIGIT_W-1:0]   a,
    input  logic [DIGIT_W-1:0]   b,
    input  logic [DIGIT_W-1:0]   d,
    input  logic [DIGIT_W-1:0]   e,
    output logic [2*DIGIT_W-1:0] t
);
    logic [2*DIGIT_W-1:0] ab_d;

    mul_add_nat #(.N(DIGIT_W)) u_mul_add (
        .a (a),
        .b (b),
        .d (d),
        .m (ab_d)
    );

    add #(.N(2*DIGIT_W)) u_add (
        .a (ab_d),
        .b ({{DIGIT_W{1'b0}}, e}),
        .s (t)
    );
endmodule

// File: rtl/seq_mul_add_nat.sv
// Sequential natural multiply-accumulate m = x*y + c, one 4-bit digit product per cycle.
// Latency: D*D busy cycles after the accepting edge; one operation in flight, no overlap.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the result is taken.
module seq_mul_add_nat
    import seq_mul_add_nat_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] m
);
    localparam int D  = N / DIGIT_W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    state_t              state;
    logic [N-1:0]        xr;
    logic [N-1:0]        yr;
    logic [2*N-1:0]      p;
    logic [DIGIT_W-1:0]  k;
    logic [CW-1:0]       i;
    logic [CW-1:0]       j;

    logic [CW:0]          lo_idx;
    logic [CW:0]          hi_idx;
    logic [DIGIT_W-1:0]   x_dig;
    logic [DIGIT_W-1:0]   y_dig;
    logic [DIGIT_W-1:0]   p_dig;
    logic [DIGIT_W-1:0]   k_in;
    logic [2*DIGIT_W-1:0] t;

    // lo_idx addresses the running partial-product digit; hi_idx the row's top digit.
    assign lo_idx = {1'b0, i} + {1'b0, j};
    assign hi_idx = {1'b0, j} + (CW+1)'(D);

    assign x_dig = xr[i*DIGIT_W +: DIGIT_W];
    assign y_dig = yr[j*DIGIT_W +: DIGIT_W];
    assign p_dig = p[lo_idx*DIGIT_W +: DIGIT_W];
    assign k_in  = (i == '0) ? '0 : k;

    digit_mac u_digit_mac (
        .a (x_dig),
        .b (y_dig),
        .d (p_dig),
        .e (k_in),
        .t (t)
    );

    assign m = p;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            xr        <= '0;
            yr        <= '0;
            p         <= '0;
            k         <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr       <= x;
                        yr       <= y;
                        p        <= {{N{1'b0}}, c};
                        k        <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    p[lo_idx*DIGIT_W +: DIGIT_W] <= t[DIGIT_W-1:0];
                    k <= t[2*DIGIT_W-1:DIGIT_W];
                    if (i == LAST) begin
                        // Row carry lands in a digit no earlier row has touched.
                        p[hi_idx*DIGIT_W +: DIGIT_W] <= t[2*DIGIT_W-1:DIGIT_W];
                        i <= '0;
                        if (j == LAST) begin
                            j         <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_add_nat.sv
// Bench for seq_mul_add_nat: N=8 and N=16 instances share the operand bus, each with its own handshake.
module tb_seq_mul_add_nat;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [15:0] c = '0;
    logic        iv  [2];
    logic        orr [2];
    logic        ir  [2];
    logic        ov  [2];
    logic [15:0] m8;
    logic [31:0] m16;

    int checks = 0;
    int fails  = 0;

    // Reference model state per instance (0: N=8, 1: N=16).
    bit          pend     [2];
    int          cnt      [2];
    logic [63:0] exp_m    [2];
    int          done_cnt [2];

    always #5 clock = ~clock;

    seq_mul_add_nat #(.N(8)) u_dut8 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .x         (x[7:0]),
        .y         (y[7:0]),
        .c         (c[7:0]),
        .out_valid (ov[0]),
        .out_ready (orr[0]),
        .m         (m8)
    );

    seq_mul_add_nat #(.N(16)) u_dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .x         (x),
        .y         (y),
        .c         (c),
        .out_valid (ov[1]),
        .out_ready (orr[1]),
        .m         (m16)
    );

    function automatic int busy_len(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    function automatic logic [63:0] mval(input int k);
        return (k == 0) ? {48'b0, m8} : {32'b0, m16};
    endfunction

    task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, got, want, $time);
        end
    endtask

    task automatic timeout(input string name, input int k);
        checks++;
        fails++;
        $display("FAIL %s inst%0d: wait bound expired at %0t", name, k, $time);
    endtask

    // Model: an accepted operation yields x*y+c after D*D edges and is held until taken.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pend[k] = 1'b0;
                cnt[k]  = 0;
            end else if (pend[k]) begin
                if (cnt[k] >= busy_len(k) && orr[k]) begin
                    pend[k] = 1'b0;
                    done_cnt[k]++;
                end else if (cnt[k] < busy_len(k)) begin
                    cnt[k]++;
                end
            end else if (iv[k]) begin
                longint unsigned xv, yv, cv;
                xv = (k == 0) ? longint'(x[7:0]) : longint'(x);
                yv = (k == 0) ? longint'(y[7:0]) : longint'(y);
                cv = (k == 0) ? longint'(c[7:0]) : longint'(c);
                exp_m[k] = xv * yv + cv;
                pend[k]  = 1'b1;
                cnt[k]   = 0;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit done_now;
            done_now = pend[k] && (cnt[k] >= busy_len(k));
            check("in_ready", k, 64'(ir[k]), 64'(!pend[k]));
            check("out_valid", k, 64'(ov[k]), 64'(done_now));
            if (done_now)
                check("m", k, mval(k), exp_m[k]);
        end
    end

    // Called and returns on a negative edge.
    task automatic run_op(input int k, input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] cv,
                          output logic [63:0] res, output int lat);
        int guard = 0;
        res = '0;
        lat = 0;
        while (!ir[k] && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!ir[k]) begin
            timeout("accept_wait", k);
            return;
        end
        x = xv; y = yv; c = cv;
        iv[k] = 1'b1;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        iv[k] = 1'b0;
        while (!ov[k] && lat < 200) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        if (!ov[k]) begin
            timeout("result_wait", k);
            return;
        end
        res = mval(k);
        orr[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        orr[k] = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        int          lat;
        int          held;
        int          guard;
        int          start;
        int          cyc;

        for (int k = 0; k < 2; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_m", 0, mval(0), 64'h0);
        check("rst_m", 1, mval(1), 64'h0);
        check("rst_in_ready", 1, 64'(ir[1]), 64'h1);
        reset = 1'b0;
        @(negedge clock);

        // Directed corner cases.
        run_op(0, 16'h00FF, 16'h00FF, 16'h0000, res, lat);
        check("n8_max_mul", 0, res, 64'hFE01);
        check("n8_latency", 0, 64'(lat), 64'd5);
        run_op(0, 16'h00FF, 16'h00FF, 16'h00FF, res, lat);
        check("n8_max_mac", 0, res, 64'hFF00);
        run_op(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, res, lat);
        check("n16_max_mac", 1, res, 64'hFFFF0000);
        check("n16_latency", 1, 64'(lat), 64'd17);
        run_op(1, 16'h0000, 16'h1234, 16'h0007, res, lat);
        check("n16_zero_x", 1, res, 64'h7);

        // Back-pressure with ignored in_valid pulses during BUSY and DONE.
        x = 16'hABCD; y = 16'h1234; c = 16'h0F0F;
        iv[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        held = 0;
        guard = 0;
        while (held < 10 && guard < 100) begin
            x = 16'($urandom); y = 16'($urandom); c = 16'($urandom);
            iv[1] = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            if (ov[1]) begin
                check("bp_hold_m", 1, mval(1), 64'h0C375EB3);
                check("bp_in_ready", 1, 64'(ir[1]), 64'h0);
                held++;
            end
            guard++;
        end
        if (held < 10) timeout("bp_result_wait", 1);
        iv[1]  = 1'b0;
        orr[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        orr[1] = 1'b0;
        check("bp_release", 1, 64'(ir[1]), 64'h1);

        // Reset in the second BUSY cycle aborts the operation.
        x = 16'h1111; y = 16'h2222; c = 16'h0000;
        iv[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iv[1] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_in_ready", 1, 64'(ir[1]), 64'h1);
        check("abort_out_valid", 1, 64'(ov[1]), 64'h0);
        check("abort_m", 1, mval(1), 64'h0);
        reset = 1'b0;
        @(negedge clock);
        run_op(1, 16'h00FF, 16'h0101, 16'h0001, res, lat);
        check("after_abort", 1, res, 64'h00010000);

        // Random traffic on both instances with random valid/ready gaps.
        start = done_cnt[1];
        cyc = 0;
        while (done_cnt[1] < start + 1000 && cyc < 60000) begin
            case ($urandom_range(0, 5))
                0:       x = 16'hFFFF;
                1:       x = 16'h0000;
                default: x = 16'($urandom);
            endcase
            y = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            c = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            for (int k = 0; k < 2; k++) begin
                iv[k]  = ($urandom_range(0, 3) == 0);
                orr[k] = ($urandom_range(0, 1) == 1);
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        if (done_cnt[1] < start + 1000) timeout("random_ops", 1);
        for (int k = 0; k < 2; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b1;
        end
        guard = 0;
        while ((pend[0] || pend[1]) && guard < 100) begin
            @(posedge clock);
            @(negedge clock);
            guard++;
        end
        if (pend[0] || pend[1]) timeout("drain", 1);
        orr[0] = 1'b0;
        orr[1] = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
